// File: rtl/alu_wide_seq.sv
// Sequencer that runs a 32-bit operation as two passes (low half, then high half)
// through the 16-bit combinational alu, chaining carry between the passes.
module alu_wide_seq #(
  parameter logic [7:0] CARRY_OPS = 8'h03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [15:0] alu_in_1,
  output logic [15:0] alu_in_2,
  output logic [2:0]  alu_select,
  output logic        alu_enable,
  output logic        alu_carry_in,
  input  logic [15:0] alu_data,
  input  logic        alu_carry_out,
  input  logic        alu_zero_flag,
  output logic [31:0] result,
  output logic        carry,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        accept_s;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [2:0]  op_r;
  logic        cin_r;
  logic        carry_lo_r;
  logic        zero_lo_r;
  logic [31:0] result_r;
  logic        carry_r;
  logic        zero_r;

  // Next-state logic; start is only honoured when no pass is in flight
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = LO;
        end else begin
          state_next_s = IDLE;
        end
      end
      LO:   state_next_s = HI;
      HI:   state_next_s = DONE;
      DONE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = LO;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture on an accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r   <= 32'h0000_0000;
      b_r   <= 32'h0000_0000;
      op_r  <= 3'd0;
      cin_r <= 1'b0;
    end else if (accept_s) begin
      a_r   <= a;
      b_r   <= b;
      op_r  <= op;
      cin_r <= cin;
    end else begin
      a_r   <= a_r;
      b_r   <= b_r;
      op_r  <= op_r;
      cin_r <= cin_r;
    end
  end

  // Result collection from each alu pass; values hold outside LO/HI
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r   <= 32'h0000_0000;
      carry_r    <= 1'b0;
      zero_r     <= 1'b0;
      carry_lo_r <= 1'b0;
      zero_lo_r  <= 1'b0;
    end else begin
      case (state_r)
        LO: begin
          result_r[15:0] <= alu_data;
          carry_lo_r     <= alu_carry_out;
          zero_lo_r      <= alu_zero_flag;
        end
        HI: begin
          result_r[31:16] <= alu_data;
          carry_r         <= alu_carry_out;
          zero_r          <= zero_lo_r & alu_zero_flag;
        end
        default: begin
          result_r   <= result_r;
          carry_r    <= carry_r;
          zero_r     <= zero_r;
          carry_lo_r <= carry_lo_r;
          zero_lo_r  <= zero_lo_r;
        end
      endcase
    end
  end

  // alu drive: decoded purely from registered state and operands
  always_comb begin
    alu_in_1     = 16'h0000;
    alu_in_2     = 16'h0000;
    alu_select   = 3'd0;
    alu_enable   = 1'b0;
    alu_carry_in = 1'b0;
    case (state_r)
      LO: begin
        alu_in_1     = a_r[15:0];
        alu_in_2     = b_r[15:0];
        alu_select   = op_r;
        alu_enable   = 1'b1;
        alu_carry_in = cin_r;
      end
      HI: begin
        alu_in_1     = a_r[31:16];
        alu_in_2     = b_r[31:16];
        alu_select   = op_r;
        alu_enable   = 1'b1;
        alu_carry_in = CARRY_OPS[op_r] ? carry_lo_r : cin_r;
      end
      default: begin
        alu_enable = 1'b0;
      end
    endcase
  end

  assign result = result_r;
  assign carry  = carry_r;
  assign zero   = zero_r;
  assign busy   = (state_r == LO) || (state_r == HI);
  assign done   = (state_r == DONE);

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: two instances (default carry mask and an all-clear mask)
// each wired to a behavioural 16-bit alu, checked against a 32-bit reference model.
module tb_alu_wide_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        cin = 1'b0;

  logic [15:0] alu_in_1, alu_in_2, alu_data;
  logic [2:0]  alu_select;
  logic        alu_enable, alu_carry_in, alu_carry_out, alu_zero_flag;
  logic [31:0] result;
  logic        carry, zero, busy, done;

  logic [15:0] alu_in_1_0, alu_in_2_0, alu_data_0;
  logic [2:0]  alu_select_0;
  logic        alu_enable_0, alu_carry_in_0, alu_carry_out_0, alu_zero_flag_0;
  logic [31:0] result_0;
  logic        carry_0, zero_0, busy_0, done_0;

  int errors = 0;
  int checks = 0;

  logic busy_h [1:5];
  logic done_h [1:5];
  logic done0_h [1:5];
  logic cin_h [1:5];
  logic cin0_h [1:5];
  logic en_h [1:5];
  logic zf_h [1:5];

  always #5 clk = ~clk;

  // Behavioural 16-bit alu: returns {zero_flag, carry_out, data}
  function automatic logic [17:0] alu_fn(input logic [15:0] x, input logic [15:0] y,
                                         input logic [2:0] s, input logic c);
    logic [16:0] t;
    case (s)
      3'd0:    t = {1'b0, x} + {1'b0, y} + {16'h0, c};
      3'd1:    t = {1'b0, x} + {1'b0, ~y} + {16'h0, c};
      3'd2:    t = {1'b0, x & y};
      3'd3:    t = {1'b0, x | y};
      3'd4:    t = {1'b0, x ^ y};
      3'd5:    t = {1'b0, ~x};
      3'd6:    t = {1'b0, x};
      default: t = {1'b0, y};
    endcase
    return {(t[15:0] == 16'h0), t};
  endfunction

  // 32-bit reference: chained ops are plain 33-bit arithmetic, others are two independent halves
  function automatic logic [33:0] ref_op(input logic [7:0] mask, input logic [31:0] x,
                                         input logic [31:0] y, input logic [2:0] s, input logic c);
    logic [32:0] w;
    logic [17:0] lo, hi;
    if (mask[s] && s == 3'd0) begin
      w = {1'b0, x} + {1'b0, y} + {32'h0, c};
    end else if (mask[s] && s == 3'd1) begin
      w = {1'b0, x} + {1'b0, ~y} + {32'h0, c};
    end else begin
      lo = alu_fn(x[15:0], y[15:0], s, c);
      hi = alu_fn(x[31:16], y[31:16], s, c);
      w  = {hi[16], hi[15:0], lo[15:0]};
    end
    return {(w[31:0] == 32'h0), w[32], w[31:0]};
  endfunction

  assign {alu_zero_flag, alu_carry_out, alu_data} =
      alu_enable ? alu_fn(alu_in_1, alu_in_2, alu_select, alu_carry_in) : 18'h0;
  assign {alu_zero_flag_0, alu_carry_out_0, alu_data_0} =
      alu_enable_0 ? alu_fn(alu_in_1_0, alu_in_2_0, alu_select_0, alu_carry_in_0) : 18'h0;

  alu_wide_seq #(.CARRY_OPS(8'h03)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_select(alu_select),
    .alu_enable(alu_enable), .alu_carry_in(alu_carry_in),
    .alu_data(alu_data), .alu_carry_out(alu_carry_out), .alu_zero_flag(alu_zero_flag),
    .result(result), .carry(carry), .zero(zero), .busy(busy), .done(done)
  );

  alu_wide_seq #(.CARRY_OPS(8'h00)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .alu_in_1(alu_in_1_0), .alu_in_2(alu_in_2_0), .alu_select(alu_select_0),
    .alu_enable(alu_enable_0), .alu_carry_in(alu_carry_in_0),
    .alu_data(alu_data_0), .alu_carry_out(alu_carry_out_0), .alu_zero_flag(alu_zero_flag_0),
    .result(result_0), .carry(carry_0), .zero(zero_0), .busy(busy_0), .done(done_0)
  );

  // Issue one operation from idle and record five cycles of handshake (index 1 = first cycle after accept)
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                        input logic tcin);
    @(negedge clk);
    a = ta; b = tb; op = top; cin = tcin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      busy_h[i]  = busy;
      done_h[i]  = done;
      done0_h[i] = done_0;
      cin_h[i]   = alu_carry_in;
      cin0_h[i]  = alu_carry_in_0;
      en_h[i]    = alu_enable;
      zf_h[i]    = alu_zero_flag;
      if (i == 1) begin
        a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7)); cin = 1'($urandom);
      end
      if (i < 5) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({result, carry, zero, busy, done} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h c=%b z=%b busy=%b done=%b, want all zero",
               result, carry, zero, busy, done);
    end
    checks++;
    if ({alu_enable, alu_in_1, alu_in_2, alu_select, alu_carry_in} !== 37'h0) begin
      errors++;
      $display("FAIL reset_alu_drive: got en=%b in1=%h in2=%h sel=%0d ci=%b, want all zero",
               alu_enable, alu_in_1, alu_in_2, alu_select, alu_carry_in);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: busy=%b want 0", busy);
    end
  endtask

  task automatic test_carry_chain();
    logic [33:0] exp;
    // Low-half overflow carried into the high half
    run_op(32'h0000_FFFF, 32'h0000_0001, 3'd0, 1'b0);
    checks++;
    if ({busy_h[1], busy_h[2], busy_h[3], done_h[2], done_h[3], done_h[4]} !== 6'b110_010) begin
      errors++;
      $display("FAIL latency: busy=%b%b%b done=%b%b%b want busy=110 done=010",
               busy_h[1], busy_h[2], busy_h[3], done_h[2], done_h[3], done_h[4]);
    end
    checks++;
    if ({result, carry, zero} !== {32'h0001_0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_ffff_1: got %h c=%b z=%b want 00010000 c=0 z=0", result, carry, zero);
    end
    checks++;
    if ({en_h[1], en_h[2], en_h[3], en_h[4]} !== 4'b1100) begin
      errors++;
      $display("FAIL enable_window: got %b%b%b%b want 1100", en_h[1], en_h[2], en_h[3], en_h[4]);
    end
    // Full wrap: chained instance carries, unchained instance uses cin in HI
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 1'b0);
    checks++;
    if ({result, carry, zero, cin_h[2]} !== {32'h0000_0000, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL add_wrap: got %h c=%b z=%b hi_cin=%b want 00000000 c=1 z=1 hi_cin=1",
               result, carry, zero, cin_h[2]);
    end
    exp = ref_op(8'h00, 32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 1'b0);
    checks++;
    if ({result_0, carry_0, zero_0, cin0_h[2]} !== {32'hFFFF_0000, 1'b0, 1'b0, 1'b0} ||
        {zero_0, carry_0, result_0} !== exp) begin
      errors++;
      $display("FAIL add_nochain: got %h c=%b z=%b hi_cin=%b want ffff0000 c=0 z=0 hi_cin=0",
               result_0, carry_0, zero_0, cin0_h[2]);
    end
  endtask

  task automatic test_zero_halves();
    run_op(32'h0001_0000, 32'h0000_0000, 3'd0, 1'b0);
    checks++;
    if ({zf_h[1], zf_h[2], result, zero} !== {1'b1, 1'b0, 32'h0001_0000, 1'b0}) begin
      errors++;
      $display("FAIL zero_halves: got lo_zf=%b hi_zf=%b res=%h z=%b want 1 0 00010000 0",
               zf_h[1], zf_h[2], result, zero);
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic        rc;
    logic [33:0] e1, e0;
    for (int n = 0; n < 20; n++) begin
      ra = $urandom; rb = $urandom; rop = 3'($urandom_range(0, 7)); rc = 1'($urandom);
      if (n < 4) rb = ~ra;
      run_op(ra, rb, rop, rc);
      e1 = ref_op(8'h03, ra, rb, rop, rc);
      e0 = ref_op(8'h00, ra, rb, rop, rc);
      checks++;
      if ({zero, carry, result} !== e1 || done_h[3] !== 1'b1) begin
        errors++;
        $display("FAIL rand_chain[%0d]: op=%0d a=%h b=%h ci=%b got z=%b c=%b r=%h done=%b want z=%b c=%b r=%h",
                 n, rop, ra, rb, rc, zero, carry, result, done_h[3], e1[33], e1[32], e1[31:0]);
      end
      checks++;
      if ({zero_0, carry_0, result_0} !== e0 || done0_h[3] !== 1'b1) begin
        errors++;
        $display("FAIL rand_nochain[%0d]: op=%0d a=%h b=%h ci=%b got z=%b c=%b r=%h want z=%b c=%b r=%h",
                 n, rop, ra, rb, rc, zero_0, carry_0, result_0, e0[33], e0[32], e0[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] dseq;
    @(negedge clk);
    a = 32'h0000_8000; b = 32'h0000_8000; op = 3'd0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    dseq[0] = done;
    a = $urandom; b = $urandom;
    @(negedge clk);
    dseq[1] = done;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== 32'h0001_0000) begin
      errors++;
      $display("FAIL b2b_first: done=%b res=%h want done=1 res=00010000", done, result);
    end
    a = 32'h1234_0000; b = 32'h0000_5678; op = 3'd0; cin = 1'b0;
    @(negedge clk);
    dseq[2] = done;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_gap: busy=%b want 1", busy);
    end
    a = $urandom; b = $urandom;
    @(negedge clk);
    dseq[3] = done;
    @(negedge clk);
    dseq[4] = done;
    start = 1'b0;
    checks++;
    if (dseq !== 5'b10000 || result !== 32'h1234_5678 || carry !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: done_seq=%b res=%h c=%b want 10000 12345678 0", dseq, result, carry);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    @(negedge clk);
    a = 32'h1111_2222; b = 32'h0000_0001; op = 3'd0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({result, done, busy, alu_enable} !== 35'h0) begin
      errors++;
      $display("FAIL reset_in_hi: res=%h done=%b busy=%b en=%b want all zero",
               result, done, busy, alu_enable);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done pulsed=%b want 0", seen_done);
    end
    run_op(32'h1111_2222, 32'h0000_0001, 3'd0, 1'b0);
    checks++;
    if (result !== 32'h1111_2223 || done_h[3] !== 1'b1) begin
      errors++;
      $display("FAIL reset_recover: res=%h done=%b want 11112223 1", result, done_h[3]);
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_zero_halves();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_wide_seq.md
Name: alu_wide_seq

Overview:
- Multi-cycle sequencer that performs 32-bit operations on the 16-bit alu datapath.
- Runs two ALU passes: low half first, then high half, chaining carry between them.
- Owns every alu control/operand input (in_1, in_2, select, enable, carry_in) and samples data, carry_out and zero_flag.
- Sits between the CPU control unit and the alu; presents a start/busy/done handshake upward.

Parameters:
- CARRY_OPS, 8'h03, bit i set means op code i chains low-pass carry_out into the high-pass carry_in; bit clear means the high pass uses cin.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- op  input  3  ALU operation; passed unchanged to alu_select.
- a  input  32  operand A; captured on accepted start.
- b  input  32  operand B; captured on accepted start.
- cin  input  1  carry into the low pass; captured on accepted start.
- alu_in_1  output  16  to alu in_1.
- alu_in_2  output  16  to alu in_2.
- alu_select  output  3  to alu select.
- alu_enable  output  1  to alu enable.
- alu_carry_in  output  1  to alu carry_in.
- alu_data  input  16  from alu data.
- alu_carry_out  input  1  from alu carry_out.
- alu_zero_flag  input  1  from alu zero_flag.
- result  output  32  final 32-bit result.
- carry  output  1  carry_out of the high pass.
- zero  output  1  1 when the full 32-bit result is zero.
- busy  output  1  high in LO and HI.
- done  output  1  one-cycle pulse in DONE.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: state=IDLE; result=0, carry=0, zero=0, busy=0, done=0; alu_enable=0, alu_in_1=0, alu_in_2=0, alu_select=0, alu_carry_in=0; internal operand/op/cin registers = 0.
- The alu is combinational; its data, carry_out and zero_flag are sampled at the end of the same cycle the sequencer drives it.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - alu_enable=0.
  - start=1 captures a, b, op, cin into registers and goes to LO.
- LO:
  - Drives alu_in_1=a[15:0], alu_in_2=b[15:0], alu_select=op, alu_carry_in=cin, alu_enable=1.
  - At the clock edge: result[15:0]<=alu_data, carry_lo<=alu_carry_out, zero_lo<=alu_zero_flag.
  - Goes to HI.
- HI:
  - Drives alu_in_1=a[31:16], alu_in_2=b[31:16], alu_select=op, alu_enable=1.
  - alu_carry_in = carry_lo if CARRY_OPS[op]=1, else cin.
  - At the clock edge: result[31:16]<=alu_data, carry<=alu_carry_out, zero<=zero_lo & alu_zero_flag.
  - Goes to DONE.
- DONE:
  - done=1, alu_enable=0.
  - start=1 accepts new operands and goes to LO (back-to-back, no IDLE gap); otherwise goes to IDLE.
- Latency: start accepted at edge N gives done=1 during cycle N+3. Throughput is one operation per 3 cycles when back-to-back.
- Output hold: result, carry and zero hold their values from the completed operation until the next accepted operation's LO/HI edges update them. They are intermediate while busy=1.
- Port changes while busy: start is ignored; a, b, op and cin may change with no effect.
- alu_enable is 1 only in LO and HI, so the alu never drives the data bus outside a pass.
- Reset asserted in LO or HI: the next state is IDLE with all reset values. No done pulse is emitted and the partial result is discarded.
- Simultaneous reset and start: reset wins and the operation is not accepted.

Test Plan:
1. Reset, then start with op=ADD (mask bit set), a=0x0000_FFFF, b=0x0000_0001, cin=0 -> done at N+3; result=0x0001_0000, carry=0, zero=0; busy high for exactly 2 cycles.
2. op=ADD, a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> result=0x0000_0000, carry=1, zero=1; alu_carry_in=1 observed during HI.
3. Instance with CARRY_OPS=8'h00, op=ADD, a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> alu_carry_in=0 in HI; result=0xFFFF_0000, carry=0, zero=0.
4. Back-to-back: start held high across DONE with a second operand set (a=0x1234_0000, b=0x0000_5678, op=ADD) -> second done exactly 3 cycles after the first; result=0x1234_5678; start pulses during busy are ignored.
5. Reset asserted in the HI cycle -> next cycle IDLE, result=0, done never pulses, alu_enable=0; a fresh start completes normally.
6. Zero flag across halves: op=ADD, a=0x0001_0000, b=0x0000_0000 -> low-pass zero_flag=1, high-pass zero_flag=0; final zero=0, result=0x0001_0000.
